spi_slave_if: RTL
=================

// Module: spi_slave_if
// PURPOSE
//  SPI target (slave) endpoint: receives a DATA_WIDTH-bit word on MOSI and returns a word on MISO,
//  MSB first, in any of the four CPOL/CPHA modes. All SPI pins are oversampled in the clk domain:
//  synchroniser, then edge detect. Sits behind a pad ring and pairs with the SPI master core over
//  an external 4-wire bus; presents a valid/ready TX side and a pulsed RX side to local logic.
// PARAMETERS
//  DATA_WIDTH   8  bits per frame (>=2)
//  CPOL         0  idle level of spi_clk
//  CPHA         0  0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
//  SYNC_STAGES  2  flops in each input synchroniser (>=2)
// PORTS
//  clk          in   1           system clock; must run at least 4x the spi_clk frequency
//  rst          in   1           synchronous, active-high reset
//  spi_clk      in   1           bus clock from master (asynchronous)
//  chip_select  in   1           active-low select from master (asynchronous)
//  mosi         in   1           serial data from master
//  miso         out  1           serial data to master
//  miso_oe      out  1           1 = drive miso pad, 0 = tristate
//  tx_data      in   DATA_WIDTH  next word to return
//  tx_valid     in   1           tx_data valid
//  tx_ready     out  1           TX buffer empty; handshake completes when tx_valid & tx_ready
//  rx_data      out  DATA_WIDTH  last received word; stable until the next rx_valid
//  rx_valid     out  1           1-cycle pulse: rx_data updated
//  frame_abort  out  1           1-cycle pulse: chip_select released mid-word
//  busy         out  1           frame in progress (state != IDLE)
// BEHAVIOUR
//  Reset: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, frame_abort=0, busy=0, state=IDLE,
//   bit_cnt=0, tx_buf empty; synchroniser flops preset to CPOL (spi_clk) and 1 (chip_select).
//  Sync: spi_clk, chip_select and mosi each pass through SYNC_STAGES flops; edges are detected by
//   comparing the last stage with one further flop. Leading edge = transition away from CPOL.
//  TX buffer: tx_valid&tx_ready loads tx_buf and drops tx_ready. The buffer is consumed
//   (tx_ready=1 next cycle) at each frame start. Empty buffer at frame start -> frame sends all-zero.
//  FSM: IDLE -> SHIFT on synchronised chip_select falling. In that same cycle, shift_reg <= tx_buf
//   (or 0) and bit_cnt <= 0.
//   SHIFT: on each sample edge, rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_sync} and bit_cnt++.
//   On each shift edge, shift_reg <<= 1.
//   CPHA=1: the first leading edge of the frame does not shift.
//   When the DATA_WIDTH-th sample is taken: rx_data <= assembled word, rx_valid=1 on the next clk,
//   and state -> DONE.
//   SHIFT + chip_select rising before DATA_WIDTH samples: frame_abort=1 for one cycle, rx_valid=0,
//   rx_data unchanged, state -> IDLE.
//   DONE: further spi_clk edges are ignored and miso=0. chip_select rising -> IDLE.
//  Outputs: miso = shift_reg[MSB] while in SHIFT, else 0. miso_oe = synchronised chip_select low.
//   busy=1 in SHIFT/DONE.
//  Latency: physical sample edge -> bit captured SYNC_STAGES+1 clk later. rx_valid follows the
//   final capture by 1 clk.
//  Simultaneous events: chip_select rising in the same cycle as the final sample edge counts as a
//   completed word (rx_valid=1, frame_abort=0).
//  A TX handshake in the same cycle as frame start loads the buffer for the NEXT frame; the current
//   frame still uses the prior tx_buf contents.
//  rst mid-frame: return to reset values at the next clk; the partial word is discarded with no
//   pulses.
//  bit_cnt is $clog2(DATA_WIDTH+1) bits wide and never wraps within a frame.
// TESTING
//  1 Mode 0, tx_buf=0xA5, master sends 0x3C at clk/10 -> rx_valid once, rx_data=0x3C,
//    master reads 0xA5.
//  2 Modes 1,2,3 each: master 0x81, tx 0x7E -> rx_data=0x81, master reads 0x7E; no frame_abort.
//  3 No tx handshake before frame: master sends 0xFF -> master reads 0x00, rx_data=0xFF,
//    tx_ready stays 1.
//  4 chip_select released after 5 bits -> frame_abort 1 pulse, no rx_valid, rx_data unchanged;
//    next full frame 0x55 passes.
//  5 12 spi_clk cycles within one select -> single rx_valid, extra bits ignored, miso=0 after bit 8.
//  6 rst asserted after bit 3 -> all outputs at reset values next clk; next frame 0xC3 received
//    correctly.

Source files
------------

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_if
//  Purpose  : Oversampled SPI target endpoint, all four CPOL/CPHA modes,
//             MSB first, valid/ready TX buffer and pulsed RX side.
//  Revision : 1.0  initial release
// ============================================================================
module spi_slave_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_clk,
    input  logic                  chip_select,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_abort,
    output logic                  busy
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic            IDLE_LVL = (CPOL != 0);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic [SYNC_STAGES-1:0]  mosi_sync;
    logic                    sclk_prev;
    logic                    cs_prev;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-2:0]   rx_shift;
    logic [DATA_WIDTH-1:0]   tx_buf;
    logic                    tx_full;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    first_edge;

    logic sclk_now, cs_now, mosi_bit;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise, word_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= IDLE_LVL;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], chip_select};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_now    = sclk_sync[SYNC_STAGES-1];
    assign cs_now      = cs_sync[SYNC_STAGES-1];
    assign mosi_bit    = mosi_sync[SYNC_STAGES-1];
    assign lead_edge   = (sclk_prev == IDLE_LVL) && (sclk_now != IDLE_LVL);
    assign trail_edge  = (sclk_prev != IDLE_LVL) && (sclk_now == IDLE_LVL);
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
    assign cs_fall     = cs_prev && !cs_now;
    assign cs_rise     = !cs_prev && cs_now;
    assign word_done   = sample_edge && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_abort <= 1'b0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            bit_cnt     <= '0;
            first_edge  <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state      <= ST_SHIFT;
                        shift_reg  <= tx_full ? tx_buf : '0;
                        tx_full    <= 1'b0;
                        bit_cnt    <= '0;
                        rx_shift   <= '0;
                        first_edge <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (sample_edge) begin
                        rx_shift <= (DATA_WIDTH-1)'({rx_shift, mosi_bit});
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                    end
                    // A release coinciding with the last sample still completes the word.
                    if (word_done) begin
                        rx_data  <= {rx_shift, mosi_bit};
                        rx_valid <= 1'b1;
                        state    <= ST_DONE;
                    end else if (cs_rise) begin
                        frame_abort <= 1'b1;
                        state       <= ST_IDLE;
                    end
                    // In CPHA=1 the MSB is already on the pin, so the first leading edge holds it.
                    if (shift_edge && !((CPHA != 0) && first_edge)) begin
                        shift_reg <= shift_reg << 1;
                    end
                    if (lead_edge) begin
                        first_edge <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (cs_now) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Loading after the frame-start consume lets a same-cycle handshake serve the next frame.
            if (tx_valid && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

    assign miso     = (state == ST_SHIFT) && shift_reg[DATA_WIDTH-1];
    assign miso_oe  = !cs_now;
    assign tx_ready = !tx_full;
    assign busy     = (state != ST_IDLE);

endmodule
`default_nettype wire
